// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: end-of-simulation controller for the RISC-V bench.
// Waits for a stable CPU halt, classifies the exit cause, runs an optional
// watchdog, and on a clean looping exit streams the signature region out
// of RAM word by word.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   halted_i, looping_i       CPU halt status and pass-path indication
//   trap_mcause_i             one-hot trap cause (bit 3 = breakpoint)
//   sig_begin_i, sig_end_i    absolute signature bounds [begin, end)
//   mem_req_o/addr_o/ack_i/data_i  RAM read port (RAM-relative byte address)
//   sig_valid_o/data_o/ready_i     signature word stream
//   done_o, exit_code_o       sticky completion flag and exit cause
//   cycle_count_o             saturating cycle counter since reset
module sim_halt_monitor #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BEGIN_ADDR = ADDR_WIDTH'(32'h4000_0000),
  parameter int unsigned           DRAIN_CYCLES   = 4,
  parameter int unsigned           TIMEOUT_CYCLES = 0,
  parameter int unsigned           MAX_WORDS      = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  halted_i,
  input  logic                  looping_i,
  input  logic [31:0]           trap_mcause_i,
  input  logic [ADDR_WIDTH-1:0] sig_begin_i,
  input  logic [ADDR_WIDTH-1:0] sig_end_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  sig_valid_o,
  output logic [DATA_WIDTH-1:0] sig_data_o,
  input  logic                  sig_ready_i,
  output logic                  done_o,
  output logic [2:0]            exit_code_o,
  output logic [31:0]           cycle_count_o
);

  localparam int unsigned           W            = DATA_WIDTH / 8;
  localparam int unsigned           OFF_W        = $clog2(W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ADDR_WIDTH'(W - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP         = ADDR_WIDTH'(W);
  localparam logic [ADDR_WIDTH-1:0] MAX_WORDS_A  = ADDR_WIDTH'(MAX_WORDS);
  localparam logic [31:0]           DRAIN_INIT   = 32'(DRAIN_CYCLES);
  localparam logic [31:0]           TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0
                                                   : 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] EXIT_PASS       = 3'd0;
  localparam logic [2:0] EXIT_BREAKPOINT = 3'd1;
  localparam logic [2:0] EXIT_EXCEPTION  = 3'd2;
  localparam logic [2:0] EXIT_TIMEOUT    = 3'd3;
  localparam logic [2:0] EXIT_BAD_RANGE  = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           drain_q, drain_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [2:0]            code_q, code_d;

  logic [ADDR_WIDTH-1:0] rel_b, rel_e, span, next_addr;
  logic                  bad_range;
  logic                  unused_mcause;

  // Only the breakpoint bit of mcause affects classification.
  assign unused_mcause = ^{trap_mcause_i[31:4], trap_mcause_i[2:0]};

  // Signature bounds relative to RAM base and their validity.
  always_comb begin
    rel_b     = sig_begin_i - RAM_BEGIN_ADDR;
    rel_e     = sig_end_i - RAM_BEGIN_ADDR;
    span      = rel_e - rel_b;
    bad_range = ((rel_b & ALIGN_MASK) != '0) ||
                ((rel_e & ALIGN_MASK) != '0) ||
                (sig_begin_i < RAM_BEGIN_ADDR) ||
                (rel_e < rel_b) ||
                ((span >> OFF_W) > MAX_WORDS_A);
  end

  assign next_addr = addr_q + STEP;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    end_d   = end_q;
    req_d   = req_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = done_q;
    code_d  = code_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    case (state_q)
      ST_RUN: begin
        if (halted_i) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_d >= TIMEOUT_LAST)) begin
          // Fires on the edge where the counter becomes TIMEOUT_CYCLES-1,
          // or immediately on return from DRAIN if that point has passed.
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = EXIT_TIMEOUT;
        end
      end

      ST_DRAIN: begin
        if (!halted_i) begin
          state_d = ST_RUN;
        end else begin
          drain_d = drain_q - 32'd1;
          if (drain_q == 32'd1) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (!looping_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = trap_mcause_i[3] ? EXIT_BREAKPOINT : EXIT_EXCEPTION;
        end else if (bad_range) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = EXIT_BAD_RANGE;
        end else if (rel_e == rel_b) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = EXIT_PASS;
        end else begin
          state_d = ST_FETCH;
          addr_d  = rel_b;
          end_d   = rel_e;
          req_d   = 1'b1;
        end
      end

      ST_FETCH: begin
        if (mem_ack_i) begin
          state_d = ST_EMIT;
          data_d  = mem_data_i;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end

      ST_EMIT: begin
        if (sig_ready_i) begin
          valid_d = 1'b0;
          addr_d  = next_addr;
          if (next_addr == end_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            code_d  = EXIT_PASS;
          end else begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign sig_valid_o   = valid_q;
  assign sig_data_o    = data_q;
  assign done_o        = done_q;
  assign exit_code_o   = code_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Testbench for sim_halt_monitor: vector table plus randomized scenarios
// against a reference model, and hand sequences for drain abort, watchdog
// and mid-fetch reset.
module tb_sim_halt_monitor;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned WB    = DW / 8;
  localparam int unsigned MAXW  = 16;
  localparam int unsigned DRAIN = 4;
  localparam logic [31:0] RAM   = 32'h4000_0000;

  typedef struct {
    bit          looping;
    logic [31:0] mcause;
    logic [31:0] sb;
    logic [31:0] se;
    int          ack_dly;
    int          rmode;
    int          code;
    int          words;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          halted_i;
  logic          looping_i;
  logic [31:0]   trap_mcause_i;
  logic [AW-1:0] sig_begin_i;
  logic [AW-1:0] sig_end_i;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic          sig_ready_i;

  logic          mem_req_o, sig_valid_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] sig_data_o;
  logic [2:0]    exit_code_o;
  logic [31:0]   cycle_count_o;

  logic          wd_mem_req_o, wd_sig_valid_o, wd_done_o;
  logic [AW-1:0] wd_mem_addr_o;
  logic [DW-1:0] wd_sig_data_o;
  logic [2:0]    wd_exit_code_o;
  logic [31:0]   wd_cycle_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sim_halt_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_BEGIN_ADDR(RAM),
    .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(0), .MAX_WORDS(MAXW)
  ) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .halted_i(halted_i), .looping_i(looping_i),
    .trap_mcause_i(trap_mcause_i), .sig_begin_i(sig_begin_i), .sig_end_i(sig_end_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o),
    .sig_ready_i(sig_ready_i), .done_o(done_o), .exit_code_o(exit_code_o),
    .cycle_count_o(cycle_count_o)
  );

  sim_halt_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_BEGIN_ADDR(RAM),
    .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(100), .MAX_WORDS(MAXW)
  ) u_wd (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .halted_i(halted_i), .looping_i(looping_i),
    .trap_mcause_i(trap_mcause_i), .sig_begin_i(sig_begin_i), .sig_end_i(sig_end_i),
    .mem_req_o(wd_mem_req_o), .mem_addr_o(wd_mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .sig_valid_o(wd_sig_valid_o), .sig_data_o(wd_sig_data_o),
    .sig_ready_i(sig_ready_i), .done_o(wd_done_o), .exit_code_o(wd_exit_code_o),
    .cycle_count_o(wd_cycle_count_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RAM contents as seen through the read port (RAM-relative address).
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] seed);
    return (a * 32'h0100_0193) ^ seed ^ {a[15:0], a[31:16]};
  endfunction

  // Exit classification and word count from the rules, in plain arithmetic.
  function automatic int ref_exit(input bit looping, input logic [31:0] mcause,
                                  input logic [31:0] sb, input logic [31:0] se,
                                  output int words);
    logic [31:0] b, e;
    words = 0;
    if (!looping) return mcause[3] ? 1 : 2;
    if (sb < RAM) return 4;
    b = sb - RAM;
    e = se - RAM;
    if ((b % WB) != 0 || (e % WB) != 0) return 4;
    if (e < b) return 4;
    if ((e - b) / WB > MAXW) return 4;
    words = int'((e - b) / WB);
    return 0;
  endfunction

  task automatic apply_reset();
    rst_n_i       = 1'b0;
    halted_i      = 1'b0;
    looping_i     = 1'b0;
    trap_mcause_i = '0;
    sig_begin_i   = '0;
    sig_end_i     = '0;
    mem_ack_i     = 1'b0;
    mem_data_i    = '0;
    sig_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ctrl", {mem_req_o, sig_valid_o, done_o, exit_code_o}, 0);
    check("rst_count", cycle_count_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", sig_data_o, 0);
    rst_n_i = 1'b1;
  endtask

  // Raise a halt with the given exit conditions, serve RAM reads, consume
  // the stream and compare against the expected exit and word list.
  task automatic run_case(input string name, input vec_t v, input logic [31:0] seed,
                          input bit do_rst);
    logic [31:0] expq[$];
    logic [31:0] rb, prev_data, prev_addr, ew;
    int          got, nreq, wait_cnt, lat;
    bit          prev_valid, prev_hs, prev_req, prev_ack, seen_done;
    if (do_rst) apply_reset();
    rb = v.sb - RAM;
    if (v.code == 0) begin
      for (int i = 0; i < v.words; i++) expq.push_back(mem_word(rb + 32'(i * WB), seed));
    end
    looping_i     = v.looping;
    trap_mcause_i = v.mcause;
    sig_begin_i   = v.sb;
    sig_end_i     = v.se;
    halted_i      = 1'b1;
    got = 0; nreq = 0; wait_cnt = 0; lat = 0;
    prev_valid = 0; prev_hs = 0; prev_req = 0; prev_ack = 0; seen_done = 0;
    prev_data = '0; prev_addr = '0;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = 32'hDEAD_BEEF;
      if (prev_valid && !prev_hs) begin
        check({name, "_stall_valid"}, sig_valid_o, 1);
        check({name, "_stall_data"}, sig_data_o, prev_data);
      end
      if (mem_req_o && prev_req && !prev_ack) check({name, "_req_addr_hold"}, mem_addr_o, prev_addr);
      if (mem_req_o && !prev_req) nreq++;
      if (done_o) begin
        seen_done = 1;
        lat = k;
        break;
      end
      prev_ack = 0;
      if (mem_req_o) begin
        wait_cnt++;
        if (wait_cnt >= v.ack_dly) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o, seed);
          wait_cnt   = 0;
          prev_ack   = 1;
        end
      end else if (v.rmode == 2) begin
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
      end
      case (v.rmode)
        0:       sig_ready_i = 1'b1;
        1:       sig_ready_i = ((k % 3) == 2);
        default: sig_ready_i = 1'($urandom_range(0, 1));
      endcase
      prev_hs = sig_valid_o && sig_ready_i;
      if (prev_hs) begin
        got++;
        if (expq.size() == 0) begin
          check({name, "_extra_word"}, got, v.words);
        end else begin
          ew = expq.pop_front();
          check({name, "_word"}, sig_data_o, ew);
        end
      end
      prev_valid = sig_valid_o;
      prev_data  = sig_data_o;
      prev_req   = mem_req_o;
      prev_addr  = mem_addr_o;
    end
    check({name, "_done"}, seen_done, 1);
    check({name, "_code"}, exit_code_o, v.code);
    check({name, "_words"}, got, v.words);
    check({name, "_reqs"}, nreq, v.words);
    if (v.words == 0) check({name, "_latency"}, lat, DRAIN + 2);
    halted_i    = 1'b0;
    looping_i   = ~v.looping;
    mem_ack_i   = 1'b1;
    sig_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check({name, "_sticky"}, {done_o, exit_code_o, sig_valid_o, mem_req_o},
          {1'b1, v.code[2:0], 2'b00});
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs [13];
    vec_t r;
    int   w, sel, len, lat;
    bit   any;

    vecs[0]  = '{1'b1, 32'h0, RAM + 32'h100, RAM + 32'h110, 2, 0, 0, 4};
    vecs[1]  = '{1'b1, 32'h0, RAM + 32'h100, RAM + 32'h110, 2, 1, 0, 4};
    vecs[2]  = '{1'b0, 32'h8, RAM + 32'h100, RAM + 32'h110, 1, 0, 1, 0};
    vecs[3]  = '{1'b0, 32'h4, RAM + 32'h100, RAM + 32'h110, 1, 0, 2, 0};
    vecs[4]  = '{1'b0, 32'hC, RAM + 32'h100, RAM + 32'h110, 1, 0, 1, 0};
    vecs[5]  = '{1'b1, 32'h0, RAM + 32'h110, RAM + 32'h100, 1, 0, 4, 0};
    vecs[6]  = '{1'b1, 32'h0, RAM + 32'h102, RAM + 32'h112, 1, 0, 4, 0};
    vecs[7]  = '{1'b1, 32'h0, RAM + 32'h100, RAM + 32'h144, 1, 0, 4, 0};
    vecs[8]  = '{1'b1, 32'h0, RAM + 32'h100, RAM + 32'h140, 1, 2, 0, 16};
    vecs[9]  = '{1'b1, 32'h0, RAM + 32'h200, RAM + 32'h200, 1, 0, 0, 0};
    vecs[10] = '{1'b1, 32'h0, RAM + 32'h100, RAM + 32'h10E, 1, 0, 4, 0};
    vecs[11] = '{1'b1, 32'h0, RAM - 32'h10,  RAM + 32'h10,  1, 0, 4, 0};
    vecs[12] = '{1'b1, 32'h0, RAM,           RAM + 32'h8,   3, 1, 0, 2};

    for (int i = 0; i < 13; i++) run_case($sformatf("vec%0d", i), vecs[i], 32'h1234_0000 + 32'(i), 1);

    // Short halt pulse aborts the drain; a held halt then classifies.
    apply_reset();
    looping_i     = 1'b0;
    trap_mcause_i = 32'h8;
    halted_i      = 1'b1;
    repeat (2) @(negedge clk_i);
    halted_i = 1'b0;
    any = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o) any = 1;
    end
    check("pulse_no_done", any, 0);
    halted_i = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check("pulse_then_hold_latency", lat, DRAIN + 2);
    check("pulse_then_hold_code", exit_code_o, 1);

    // Watchdog fires with the counter at 99; disabled instance stays idle.
    apply_reset();
    repeat (10) @(negedge clk_i);
    check("count_after_10", wd_cycle_count_o, 10);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (wd_done_o) break;
    end
    check("wd_done", wd_done_o, 1);
    check("wd_code", wd_exit_code_o, 3);
    check("wd_count_at_done", wd_cycle_count_o, 99);
    check("no_wd_when_disabled", done_o, 0);
    repeat (5) @(negedge clk_i);
    check("count_after_done", wd_cycle_count_o, 104);

    // Halt arriving in the same cycle as the timeout wins.
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      if (wd_cycle_count_o == 98) break;
      @(negedge clk_i);
    end
    halted_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (wd_done_o) break;
    end
    check("halt_wins_done", wd_done_o, 1);
    check("halt_wins_code", wd_exit_code_o, 2);
    check("halt_wins_count", wd_cycle_count_o, 98 + DRAIN + 2);

    // Reset in the middle of a fetch, then a complete fresh dump.
    apply_reset();
    looping_i   = 1'b1;
    sig_begin_i = RAM + 32'h100;
    sig_end_i   = RAM + 32'h110;
    halted_i    = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (mem_req_o) break;
    end
    check("pre_rst_req", mem_req_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("midrst_ctrl", {mem_req_o, sig_valid_o, done_o, exit_code_o}, 0);
    check("midrst_addr", mem_addr_o, 0);
    check("midrst_data", sig_data_o, 0);
    check("midrst_count", cycle_count_o, 0);
    halted_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_case("after_midrst", vecs[0], 32'hCAFE_0000, 0);

    // Randomized exits against the reference model.
    for (int n = 0; n < 30; n++) begin
      r.looping = ($urandom_range(0, 3) != 0);
      r.mcause  = $urandom;
      r.sb      = RAM + 32'($urandom_range(0, 255)) * 32'd4;
      sel       = int'($urandom_range(0, 7));
      len       = int'($urandom_range(0, MAXW));
      r.se      = r.sb + 32'(len * 4);
      if (sel == 0) r.sb = r.sb + 32'($urandom_range(1, 3));
      if (sel == 1) r.se = r.sb - 32'($urandom_range(1, 4) * 4);
      if (sel == 2) r.se = r.sb + 32'((MAXW + $urandom_range(1, 3)) * 4);
      if (sel == 3) r.sb = RAM - 32'($urandom_range(1, 8) * 4);
      r.ack_dly = int'($urandom_range(1, 3));
      r.rmode   = 2;
      r.code    = ref_exit(r.looping, r.mcause, r.sb, r.se, w);
      r.words   = w;
      run_case($sformatf("rand%0d", n), r, $urandom, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_halt_monitor.md
Name: sim_halt_monitor

Overview:
- Parametrised end-of-simulation controller for the pipelined RISC-V bench; replaces the ad-hoc halt/finish logic in the sim top.
- Watches CPU halt status and applies a programmable drain delay. Classifies the exit cause and enforces a watchdog timeout.
- On a clean looping exit, walks the signature region in RAM through a memory read port. Streams the words out over a valid/ready interface for the bench to write to file.
- The bench calls $finish only after done_o rises.

Parameters:
ADDR_WIDTH, 32, byte address width of the signature bounds and the memory port
DATA_WIDTH, 32, signature word width; must be 16, 32 or 64
RAM_BEGIN_ADDR, 32'h4000_0000, base subtracted from CPU addresses to form the RAM-relative address
DRAIN_CYCLES, 4, number of cycles halted_i must stay high before the exit is classified
TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog
MAX_WORDS, 4096, maximum number of signature words allowed

Ports:
clk_i  in  1  bench/CPU clock
rst_n_i  in  1  reset, asynchronous, active-low
halted_i  in  1  CPU is in the halted state
looping_i  in  1  halt was caused by a looping instruction (pass path)
trap_mcause_i  in  32  one-hot trap cause bits; bit 3 = breakpoint
sig_begin_i  in  ADDR_WIDTH  signature start byte address (absolute); sampled in CHECK
sig_end_i  in  ADDR_WIDTH  signature end byte address, exclusive; sampled in CHECK
mem_req_o  out  1  RAM read request
mem_addr_o  out  ADDR_WIDTH  RAM-relative byte address of the read
mem_ack_i  in  1  one-cycle read acknowledge; mem_data_i is valid in the same cycle
mem_data_i  in  DATA_WIDTH  read data
sig_valid_o  out  1  a signature word is available on sig_data_o
sig_data_o  out  DATA_WIDTH  signature word
sig_ready_i  in  1  bench accepts the current word
done_o  out  1  monitor finished; sticky until reset
exit_code_o  out  3  exit code: 0 PASS, 1 BREAKPOINT, 2 EXCEPTION, 3 TIMEOUT, 4 BAD_RANGE
cycle_count_o  out  32  cycles counted since reset; saturates at all-ones

Behaviour:
- Reset: asserting rst_n_i low clears all state immediately, including mid-fetch or mid-emit. mem_req_o, sig_valid_o and done_o go to 0. exit_code_o, cycle_count_o, mem_addr_o and sig_data_o go to 0. State returns to RUN.
- cycle_count_o increments by 1 every cycle after reset and saturates at all-ones. It keeps counting after done_o.
- Addresses advance by W = DATA_WIDTH/8 per word.
- RUN state:
  - If halted_i=1, go to DRAIN and load the drain counter with DRAIN_CYCLES.
  - Otherwise, if TIMEOUT_CYCLES≠0 and cycle_count_o reaches TIMEOUT_CYCLES-1, go to DONE with code 3.
  - If halt and timeout occur in the same cycle, halt wins.
- DRAIN state:
  - The counter decrements each cycle.
  - If halted_i drops, return to RUN; the watchdog is not reset.
  - When the counter reaches 0 with halted_i still high, go to CHECK.
  - With DRAIN_CYCLES=0, go from RUN directly to CHECK.
- CHECK state (one cycle):
  - looping_i=0 and trap_mcause_i[3]=1: go to DONE, code 1.
  - looping_i=0 otherwise: go to DONE, code 2.
  - looping_i=1: compute b = sig_begin_i - RAM_BEGIN_ADDR and e = sig_end_i - RAM_BEGIN_ADDR.
  - Code 4 (BAD_RANGE) if any of these hold: b or e is misaligned to W; sig_begin_i < RAM_BEGIN_ADDR; e < b; (e-b)/W > MAX_WORDS.
  - If e == b: go to DONE with code 0 and emit no words.
  - Otherwise load addr=b and go to FETCH.
- FETCH state:
  - mem_req_o=1 and mem_addr_o=addr.
  - Hold both stable until a cycle with mem_ack_i=1.
  - In that cycle, latch mem_data_i into sig_data_o, drop mem_req_o on the next edge, and go to EMIT.
  - Minimum latency is 1 cycle from request to ack.
  - mem_ack_i is ignored outside FETCH.
- EMIT state:
  - sig_valid_o=1.
  - sig_data_o is held stable until a cycle with sig_ready_i=1; in that cycle addr += W.
  - If the new addr == e, go to DONE with code 0. Otherwise go to FETCH.
  - Valid must not drop without a ready handshake.
  - Words are emitted in ascending address order, exactly (e-b)/W of them.
- DONE state: done_o=1 and exit_code_o are held until reset; all inputs are ignored.
- Address arithmetic is ADDR_WIDTH-bit unsigned; the end comparison is equality on the aligned address, so there is no wrap.

Test Plan:
1. DRAIN_CYCLES=4. Raise halted_i with looping_i=1, sig_begin_i=RAM_BEGIN_ADDR+0x100, sig_end_i=+0x110. RAM returns ack 2 cycles after each request; sig_ready_i is always high. Expect exactly 4 words from relative addresses 0x100, 0x104, 0x108, 0x10C, in that order, followed by done_o=1 with exit_code_o=0.
2. Same as scenario 1, but sig_ready_i toggles 0,0,1. Expect sig_data_o and sig_valid_o stable across the stall cycles, no duplicated or lost words, and 4 words total.
3. Pulse halted_i high for 2 cycles, then drop it, with DRAIN_CYCLES=4. Expect a return to RUN and no done_o. Then hold halted_i with looping_i=0 and trap_mcause_i=32'h8. Expect done_o with code 1. Repeat with trap_mcause_i=32'h4; expect code 2.
4. TIMEOUT_CYCLES=100 and halted_i never rises. Expect done_o rising with code 3 when cycle_count_o=99. Repeat with halted_i rising at cycle 99; expect the halt path to be taken, not timeout.
5. Range errors: e < b, b misaligned by 2, and a size of MAX_WORDS+1 words. Each case must give code 4 with zero memory requests. e == b must give code 0 with zero words.
6. Drop rst_n_i during FETCH with mem_req_o=1. Expect all outputs to be 0 immediately. After release, a fresh halt must run a complete new dump.
